// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a one-cycle instruction memory and
// feeds a registered IF/ID stage with stall skid buffering, redirect squash and halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd2,
  parameter logic [15:0] HALT_INST = 16'hEFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] im_addr,
  input  logic [15:0] im_inst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ifid_valid,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] f1_pc;
  logic        f1_v;
  logic [15:0] skid;
  logic        skid_v;
  logic [15:0] word;

  assign im_addr = pc;
  // A word parked during a stall is older than whatever memory now returns.
  assign word    = skid_v ? skid : im_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      f1_pc      <= 16'h0000;
      f1_v       <= 1'b0;
      skid       <= 16'h0000;
      skid_v     <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_inst  <= 16'h0000;
      ifid_pc    <= 16'h0000;
      halted     <= 1'b0;
    end else if (redirect) begin
      state      <= RUN;
      pc         <= {redirect_pc[15:1], 1'b0};
      f1_v       <= 1'b0;
      skid_v     <= 1'b0;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else if (state == HALT) begin
      if (!stall) begin
        ifid_valid <= 1'b0;
      end
    end else if (stall) begin
      // Memory re-reads pc at this edge, so the in-flight word must be captured now.
      if (f1_v && !skid_v) begin
        skid   <= im_inst;
        skid_v <= 1'b1;
      end
    end else begin
      ifid_valid <= f1_v;
      ifid_inst  <= word;
      ifid_pc    <= f1_pc;
      skid_v     <= 1'b0;
      pc         <= pc + PC_STEP;
      f1_pc      <= pc;
      if (f1_v && word == HALT_INST) begin
        state  <= HALT;
        halted <= 1'b1;
        f1_v   <= 1'b0;
      end else begin
        f1_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stall/redirect
// traffic compared every cycle against a stream-level model of delivered instructions.
module tb_fetch_unit;

  localparam logic [15:0] HALT_WORD = 16'hEFFF;

  logic        clk;
  logic        rst;
  logic [15:0] im_addr;
  logic [15:0] im_inst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_inst;
  logic [15:0] ifid_pc;
  logic        halted;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .im_addr    (im_addr),
    .im_inst    (im_inst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ifid_valid (ifid_valid),
    .ifid_inst  (ifid_inst),
    .ifid_pc    (ifid_pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with one-cycle registered read.
  logic [15:0] mem [0:32767];
  initial im_inst = 16'h0000;
  always @(posedge clk) im_inst <= mem[im_addr[15:1]];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the program-order stream of words the decoder should see.
  logic [15:0] m_next;
  logic        m_warm;
  logic        m_valid;
  logic [15:0] m_inst;
  logic [15:0] m_pc;
  logic        m_halted;

  task automatic model_reset();
    m_next   = 16'h0000;
    m_warm   = 1'b1;
    m_valid  = 1'b0;
    m_inst   = 16'h0000;
    m_pc     = 16'h0000;
    m_halted = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic [15:0] rpc, input logic s);
    if (r) begin
      m_next   = {rpc[15:1], 1'b0};
      m_warm   = 1'b1;
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      if (!s) m_valid = 1'b0;
    end else if (s) begin
      // decode holds what it has; nothing advances
    end else if (m_warm) begin
      m_warm  = 1'b0;
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_inst  = mem[m_next[15:1]];
      m_pc    = m_next;
      m_next  = m_next + 16'd2;
      if (m_inst == HALT_WORD) m_halted = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_addr;
    exp_addr = m_warm ? m_next : m_next + 16'd2;
    check("valid", {31'd0, ifid_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("inst", {16'd0, ifid_inst}, {16'd0, m_inst});
      check("pc", {16'd0, ifid_pc}, {16'd0, m_pc});
    end
    check("halted", {31'd0, halted}, {31'd0, m_halted});
    check("im_addr", {16'd0, im_addr}, {16'd0, exp_addr});
  endtask

  task automatic cycle(input logic r, input logic [15:0] rpc, input logic s);
    redirect    = r;
    redirect_pc = rpc;
    stall       = s;
    @(posedge clk);
    model_edge(r, rpc, s);
    @(negedge clk);
    compare_all();
  endtask

  // Called at a negedge; reset takes effect without waiting for a clock edge.
  task automatic assert_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_inst", {16'd0, ifid_inst}, 32'd0);
    check("rst_pc", {16'd0, ifid_pc}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_addr", {16'd0, im_addr}, 32'd0);
    model_reset();
  endtask

  task automatic release_reset();
    stall    = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    for (int i = 0; i < 32768; i++) mem[i] = {1'b0, i[14:0]};
    mem[16'h0000 >> 1] = 16'hF120;
    mem[16'h0002 >> 1] = 16'hF121;
    mem[16'h0004 >> 1] = 16'h93FF;
    mem[16'h001A >> 1] = 16'hA1A1;
    mem[16'h0036 >> 1] = HALT_WORD;
    mem[16'hFFFE >> 1] = 16'hB00B;
    model_reset();
    @(negedge clk);
    assert_reset();
    release_reset();

    $display("scenario reset/stream");
    cycle(0, 0, 0);
    check("e1_valid", {31'd0, ifid_valid}, 32'd0);
    cycle(0, 0, 0);
    check("e2_inst", {16'd0, ifid_inst}, 32'h0000F120);
    check("e2_addr", {16'd0, im_addr}, 32'h4);

    $display("scenario stall");
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1);
      check("stall_inst", {16'd0, ifid_inst}, 32'h0000F120);
      check("stall_addr", {16'd0, im_addr}, 32'h4);
    end
    cycle(0, 0, 0);
    check("rel_inst", {16'd0, ifid_inst}, 32'h0000F121);
    cycle(0, 0, 0);
    check("rel2_inst", {16'd0, ifid_inst}, 32'h000093FF);
    check("rel2_pc", {16'd0, ifid_pc}, 32'h4);

    $display("scenario redirect");
    cycle(1, 16'h001B, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("redir_inst", {16'd0, ifid_inst}, 32'h0000A1A1);
    check("redir_pc", {16'd0, ifid_pc}, 32'h1A);
    cycle(1, 16'h0040, 1);
    check("redir_stall_valid", {31'd0, ifid_valid}, 32'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    $display("scenario halt");
    cycle(1, 16'h0030, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    check("halt_inst", {16'd0, ifid_inst}, {16'd0, HALT_WORD});
    check("halt_pc", {16'd0, ifid_pc}, 32'h36);
    check("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0);
      check("halt_quiet", {31'd0, ifid_valid}, 32'd0);
      check("halt_addr", {16'd0, im_addr}, 32'h3A);
    end

    $display("scenario halt exit");
    cycle(1, 16'h0000, 0);
    check("exit_halted", {31'd0, halted}, 32'd0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("exit_inst", {16'd0, ifid_inst}, 32'h0000F120);

    $display("scenario wrap");
    cycle(1, 16'hFFFE, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("wrap_pc0", {16'd0, ifid_pc}, 32'hFFFE);
    cycle(0, 0, 0);
    check("wrap_pc1", {16'd0, ifid_pc}, 32'h0000);

    $display("scenario reset mid-stall");
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    assert_reset();
    release_reset();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("restart_inst", {16'd0, ifid_inst}, 32'h0000F120);
    cycle(0, 0, 0);
    check("restart_pc", {16'd0, ifid_pc}, 32'h2);

    $display("scenario random traffic");
    rst = 1'b0;
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      mem[i] = (v == HALT_WORD) ? 16'h0000 : v;
    end
    for (int i = 0; i < 8; i++) mem[$urandom_range(0, 127)] = HALT_WORD;
    assert_reset();
    release_reset();
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic        s;
      logic [15:0] t;
      r = ($urandom_range(0, 99) < 4) || (m_halted && $urandom_range(0, 7) == 0);
      t = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      s = $urandom_range(0, 99) < 30;
      cycle(r, t, s);
      if (i == 700) begin
        assert_reset();
        release_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and program-counter owner: the requesting side of the instruction-memory interface. It drives a byte address to the instruction memory, which has a one-cycle registered read. It then pairs each returned 16-bit word with the PC that fetched it and presents both to decode through a registered IF/ID stage. It supports decode stalls with no lost instruction, branch redirects with squash, and halts on the end-of-program word.

## Interface
- RESET_PC, 16'h0000, first fetch address after reset
- PC_STEP, 2, byte increment per instruction; words sit at even addresses
- HALT_INST, 16'hEFFF, end-of-program instruction word
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- im_addr  out  16  address to instruction memory; equals internal pc register
- im_inst  in  16  memory read data; holds mem[address sampled at previous edge]
- stall  in  1  decode cannot accept; hold IF/ID
- redirect  in  1  branch taken; flush and refetch from redirect_pc
- redirect_pc  in  16  target byte address; bit 0 forced to 0
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_inst  out  16  instruction word
- ifid_pc  out  16  byte address of ifid_inst
- halted  out  1  HALT_INST has been delivered; fetch frozen

## Operation
- Internal state:
  - pc, the address currently on im_addr
  - f1_pc/f1_v, the address in flight whose data is on im_inst this cycle
  - skid/skid_v, a one-entry buffer
  - state RUN / HALT
- Reset values: pc=RESET_PC; f1_v=0; skid_v=0; ifid_valid=0; ifid_inst=0; ifid_pc=0; halted=0; state=RUN. im_inst is undefined during and right after reset and is ignored while f1_v=0.
- Each edge applies the first matching rule, in priority order:
  - **redirect (any state):** pc<=redirect_pc&~1; f1_v<=0; skid_v<=0; ifid_valid<=0; state<=RUN; halted<=0.
  - **HALT state:** all registers hold; f1_v stays 0.
  - **stall:** pc, f1 and IF/ID hold. If f1_v and !skid_v, then skid<=im_inst and skid_v<=1, because memory re-reads pc at this edge and would lose the word.
  - **normal (RUN, !stall):**
    - Source word w = skid_v ? skid : im_inst.
    - IF/ID <= {f1_v, w, f1_pc}; skid_v<=0.
    - pc<=pc+PC_STEP, mod 2^16, wrapping 16'hFFFE to 16'h0000.
    - f1_pc<=pc; f1_v<=1.
    - If f1_v and w==HALT_INST: state<=HALT, halted<=1, f1_v<=0. The halt word itself is delivered valid; younger fetches are squashed.
- In HALT, ifid_valid drops at the next edge unless stall is asserted, in which case IF/ID holds.
- HALT is left only by redirect or reset.

## Timing
- Memory latency is 1 cycle; IF/ID adds 1 cycle, so a word is valid on the IF/ID outputs 2 edges after its address first appears on im_addr.
- After reset release: edge 1 launches RESET_PC; edge 2 gives ifid_valid=1 with the word at RESET_PC.
- Steady state delivers one instruction per cycle with no bubbles.
- Stall: zero-bubble restart. The edge after stall drops delivers the skid word, then im_inst words follow back-to-back.
- Redirect penalty: ifid_valid=0 for the edges after the redirect edge, then the redirect_pc word is valid 2 edges after the redirect edge.
- Redirect concurrent with stall: redirect wins; IF/ID is squashed (ifid_valid<=0) even though stall is high.
- Asynchronous reset mid-operation immediately forces all outputs to their reset values; im_addr=RESET_PC.

## Test plan
- **Reset/stream:** memory 0:F120, 2:F121, 4:93FF; release rst -> ifid_valid=1 at edge 2 with F120/pc 0, then F121/2 and 93FF/4 on consecutive edges.
- **Stall:** stall high for 3 edges while IF/ID=F120/0 -> IF/ID holds F120/0 through the stall; im_addr holds 4; on release the sequence is F121/2 then 93FF/4, with nothing dropped or duplicated.
- **Redirect:** with redirect=1 and redirect_pc=16'h001B -> ifid_valid=0 for 1 edge; next valid is mem[1A] with pc 16'h001A; redirect together with stall also squashes.
- **Halt:** mem[36]=EFFF -> delivered valid with pc 36; halted=1; next edge ifid_valid=0; im_addr frozen; 5 more edges produce no valid.
- **Halt exit:** redirect to 0 while halted -> halted=0; F120/0 is valid 2 edges later.
- **Wrap and reset:** redirect to 16'hFFFE -> next PCs are FFFE then 0000. Assert rst mid-stall with the skid full -> outputs clear immediately; the restart fetches RESET_PC cleanly.
